scr1_dmi_scan_ctrl: RTL



---
 rtl/scr1_dmi_scan_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/scr1_dmi_scan_ctrl.sv
// -----------------------------------------------------------------------------
// scr1_dmi_scan_ctrl
//
// Purpose:
//   DMI/DTMCS scan-chain engine in the SysCLK domain. It sits directly after the
//   TAPC clock-domain synchronizer and consumes its single-cycle
//   capture/shift/update strobes and the TDI bit. It returns TDO.
//   The block owns two shift registers:
//     - the 41-bit DMI register {addr, data, op};
//     - the 32-bit DTMCS register.
//   A DMI update becomes a request/response transaction toward the Debug
//   Module. The sticky DMI error status is reported through op (DMI capture)
//   and dmistat (DTMCS capture).
//
// Ports:
//   clk         in   SysCLK
//   rst_n       in   synchronous active-low reset
//   ch_sel      in   chain select (level)
//   ch_id       in   chain identifier (level): DTMCS_ID or DMI_ID
//   ch_capture  in   capture strobe, one cycle
//   ch_shift    in   shift strobe, one cycle
//   ch_update   in   update strobe, one cycle
//   ch_tdi      in   TDI bit, valid with ch_shift
//   ch_tdo      out  TDO bit (bit 0 of the active shift register)
//   dmi_req     out  request to DM, held until dmi_resp
//   dmi_wr      out  1 = write, 0 = read
//   dmi_addr    out  request address
//   dmi_wdata   out  request write data
//   dmi_resp    in   DM completion pulse, one cycle
//   dmi_rdata   in   DM read data, valid with dmi_resp
// -----------------------------------------------------------------------------
module scr1_dmi_scan_ctrl #(
  parameter int                   ADDR_W   = 7,
  parameter int                   DATA_W   = 32,
  parameter int                   CH_ID_W  = 2,
  parameter logic [CH_ID_W-1:0]   DTMCS_ID = 2'd1,
  parameter logic [CH_ID_W-1:0]   DMI_ID   = 2'd2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ch_sel,
  input  logic [CH_ID_W-1:0]  ch_id,
  input  logic                ch_capture,
  input  logic                ch_shift,
  input  logic                ch_update,
  input  logic                ch_tdi,
  output logic                ch_tdo,
  output logic                dmi_req,
  output logic                dmi_wr,
  output logic [ADDR_W-1:0]   dmi_addr,
  output logic [DATA_W-1:0]   dmi_wdata,
  input  logic                dmi_resp,
  input  logic [DATA_W-1:0]   dmi_rdata
);

  localparam int         DSR_W = ADDR_W + DATA_W + 2;
  localparam int         TSR_W = 32;
  localparam logic [5:0] ABITS = 6'(ADDR_W);

  // DMI op field encodings
  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_BUSY  = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_reg;
  logic [DSR_W-1:0]    dsr_reg;
  logic [TSR_W-1:0]    tsr_reg;
  logic [ADDR_W-1:0]   last_addr_reg;
  logic [DATA_W-1:0]   last_rdata_reg;
  logic [1:0]          sticky_reg;

  // ---------------------------------------------------------------------------
  // Chain decode and strobe priority.
  // The strobes should never coincide. If they do, update beats capture, and
  // capture beats shift.
  // ---------------------------------------------------------------------------
  logic dmi_active;
  logic dtm_active;
  logic upd_sel;
  logic cap_sel;
  logic sh_sel;

  assign dmi_active = ch_sel && (ch_id == DMI_ID);
  assign dtm_active = ch_sel && (ch_id == DTMCS_ID);

  assign upd_sel = ch_update;
  assign cap_sel = ch_capture && !ch_update;
  assign sh_sel  = ch_shift && !ch_update && !ch_capture;

  logic dmi_upd;
  logic dmi_cap;
  logic dmi_sh;
  logic dtm_upd;
  logic dtm_cap;
  logic dtm_sh;

  assign dmi_upd = dmi_active && upd_sel;
  assign dmi_cap = dmi_active && cap_sel;
  assign dmi_sh  = dmi_active && sh_sel;
  assign dtm_upd = dtm_active && upd_sel;
  assign dtm_cap = dtm_active && cap_sel;
  assign dtm_sh  = dtm_active && sh_sel;

  // ---------------------------------------------------------------------------
  // Derived control
  // ---------------------------------------------------------------------------
  logic        busy;
  logic [1:0]  upd_op;
  logic        upd_is_rw;
  logic        hard_reset;
  logic        soft_reset;
  logic        resp_done;
  logic [1:0]  cap_op;
  logic [TSR_W-1:0] tsr_cap;

  assign busy      = (state_reg == BUSY);
  assign upd_op    = dsr_reg[1:0];
  assign upd_is_rw = (upd_op == OP_READ) || (upd_op == OP_WRITE);

  // dmihardreset (bit 17) also aborts the transaction in flight.
  // A response arriving in that same cycle is discarded, so the hard reset
  // must gate the response handling below.
  assign hard_reset = dtm_upd && tsr_reg[17];
  assign soft_reset = dtm_upd && tsr_reg[16];
  assign resp_done  = busy && dmi_resp && !hard_reset;

  // Captured op. An existing sticky error wins. If there is none, a capture
  // that finds a transaction still in flight reports busy (3) and makes it
  // sticky. The state is the pre-edge state, so a response landing in the same
  // cycle still counts as busy.
  always_comb begin
    cap_op = OP_NOP;
    if (sticky_reg != 2'd0) begin
      cap_op = sticky_reg;
    end else if (busy) begin
      cap_op = OP_BUSY;
    end
  end

  // DTMCS capture image.
  // Fields, from MSB down: 14 zeros, dmihardreset/dmireset/reserved (read 0),
  // idle = 1, dmistat = sticky, abits, version = 1.
  assign tsr_cap = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, sticky_reg, ABITS, 4'd1};

  // TDO follows bit 0 of whichever chain is currently selected. It is forced
  // low when no chain is selected.
  always_comb begin
    ch_tdo = 1'b0;
    if (dmi_active) begin
      ch_tdo = dsr_reg[0];
    end else if (dtm_active) begin
      ch_tdo = tsr_reg[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Registered state: FSM, shift registers, request payload, sticky status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      dmi_req        <= 1'b0;
      dmi_wr         <= 1'b0;
      dmi_addr       <= '0;
      dmi_wdata      <= '0;
      dsr_reg        <= '0;
      tsr_reg        <= '0;
      last_addr_reg  <= '0;
      last_rdata_reg <= '0;
      sticky_reg     <= 2'd0;
    end else begin
      // DM completion. A write leaves the previous read data in place.
      if (resp_done) begin
        state_reg     <= IDLE;
        dmi_req       <= 1'b0;
        last_addr_reg <= dmi_addr;
        if (!dmi_wr) begin
          last_rdata_reg <= dmi_rdata;
        end
      end

      // DMI chain
      if (dmi_upd) begin
        if (upd_is_rw) begin
          if (busy) begin
            // Overrun: drop the request and flag it.
            sticky_reg <= OP_BUSY;
          end else if (sticky_reg == 2'd0) begin
            dmi_addr  <= dsr_reg[DSR_W-1 -: ADDR_W];
            dmi_wdata <= dsr_reg[DATA_W+1:2];
            dmi_wr    <= (upd_op == OP_WRITE);
            dmi_req   <= 1'b1;
            state_reg <= BUSY;
          end
          // If sticky is already set and the FSM is idle, the request is
          // silently dropped and sticky is left as it is.
        end
      end else if (dmi_cap) begin
        dsr_reg <= {last_addr_reg, last_rdata_reg, cap_op};
        if ((sticky_reg == 2'd0) && busy) begin
          sticky_reg <= OP_BUSY;
        end
      end else if (dmi_sh) begin
        dsr_reg <= {ch_tdi, dsr_reg[DSR_W-1:1]};
      end

      // DTMCS chain. The DMI and DTMCS selects are exclusive, so these sticky
      // and FSM writes never collide with the DMI writes above.
      if (dtm_upd) begin
        if (soft_reset || hard_reset) begin
          sticky_reg <= 2'd0;
        end
        if (hard_reset) begin
          state_reg <= IDLE;
          dmi_req   <= 1'b0;
        end
      end else if (dtm_cap) begin
        tsr_reg <= tsr_cap;
      end else if (dtm_sh) begin
        tsr_reg <= {ch_tdi, tsr_reg[TSR_W-1:1]};
      end
    end
  end

endmodule
